// File: rtl/cond_unit_e_pkg.sv
// cond_unit_e_pkg
// Shared definitions for the execute-stage condition unit: ARM condition
// field encoding, RISC-V branch funct3 values and NZCV bit positions.
package cond_unit_e_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

endpackage

// File: rtl/cond_unit_e_check.sv
// cond_check
// Purely combinational condition evaluation.
//   armE     : 1 = evaluate ARM CondE against stored FlagsE
//   CondE    : ARM condition field
//   Funct3E  : RISC-V branch funct3
//   FlagsE   : architectural NZCV register
//   ALUFlags : NZCV of this cycle's Op1-Op2 subtract (RISC-V compares)
//   CondExE  : condition passes (always 1 for RISC-V)
//   BrOk     : RISC-V branch comparison outcome
module cond_check
  import cond_unit_e_pkg::*;
(
  input  logic       armE,
  input  logic [3:0] CondE,
  input  logic [2:0] Funct3E,
  input  logic [3:0] FlagsE,
  input  logic [3:0] ALUFlags,
  output logic       CondExE,
  output logic       BrOk
);

  logic n, z, c, v;
  logic an, az, ac, av;

  assign n  = FlagsE[N_IDX];
  assign z  = FlagsE[Z_IDX];
  assign c  = FlagsE[C_IDX];
  assign v  = FlagsE[V_IDX];
  assign an = ALUFlags[N_IDX];
  assign az = ALUFlags[Z_IDX];
  assign ac = ALUFlags[C_IDX];
  assign av = ALUFlags[V_IDX];

  always_comb begin
    CondExE = 1'b1;
    BrOk    = 1'b0;
    if (armE) begin
      case (cond_t'(CondE))
        COND_EQ: CondExE = z;
        COND_NE: CondExE = ~z;
        COND_CS: CondExE = c;
        COND_CC: CondExE = ~c;
        COND_MI: CondExE = n;
        COND_PL: CondExE = ~n;
        COND_VS: CondExE = v;
        COND_VC: CondExE = ~v;
        COND_HI: CondExE = c & ~z;
        COND_LS: CondExE = ~c | z;
        COND_GE: CondExE = (n == v);
        COND_LT: CondExE = (n != v);
        COND_GT: CondExE = ~z & (n == v);
        COND_LE: CondExE = z | (n != v);
        COND_AL: CondExE = 1'b1;
        COND_NV: CondExE = 1'b1;
        default: CondExE = 1'b1;
      endcase
    end else begin
      // ALU carry is a borrow flag here: C=1 means Op1 < Op2 unsigned.
      case (Funct3E)
        F3_BEQ:  BrOk = az;
        F3_BNE:  BrOk = ~az;
        F3_BLT:  BrOk = an ^ av;
        F3_BGE:  BrOk = ~(an ^ av);
        F3_BLTU: BrOk = ac;
        F3_BGEU: BrOk = ~ac;
        default: BrOk = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/cond_unit_e.sv
// cond_unit_e
// Execute-stage condition/branch unit for the combined ARM/RISC-V pipeline.
// Holds the ARM NZCV register, evaluates conditions/branches and gates the
// write enables of the instruction in E.
//   clk, reset            : clock, synchronous active-high reset
//   armE, ValidE          : ISA select, non-bubble instruction in E
//   StallE, FlushE        : E held / E squashed this cycle
//   CondE, Funct3E        : ARM condition / RISC-V branch funct3
//   BranchE, JumpE        : branch / unconditional RISC-V jump
//   FlagWriteE            : [1] write N,Z  [0] write C,V (ARM only)
//   RegWriteE, MemWriteE  : ungated write enables
//   ALUFlags              : NZCV from the ALU this cycle
//   FlagsE                : stored NZCV, fed back to the ALU
//   CondExE, PCSrcE       : executes / redirect fetch
//   RegWriteGE, MemWriteGE: gated write enables
//   BranchTakenM          : registered PCSrcE for hazard flushing
module cond_unit_e
  import cond_unit_e_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       armE,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondE,
  input  logic [2:0] Funct3E,
  input  logic       BranchE,
  input  logic       JumpE,
  input  logic [1:0] FlagWriteE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic [3:0] ALUFlags,
  output logic [3:0] FlagsE,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic       BranchTakenM
);

  logic [3:0] flags_q;
  logic       live;
  logic       cond_raw;
  logic       br_ok;
  logic       pcsrc_raw;
  logic       flag_we;

  cond_check u_cond_check (
    .armE     (armE),
    .CondE    (CondE),
    .Funct3E  (Funct3E),
    .FlagsE   (flags_q),
    .ALUFlags (ALUFlags),
    .CondExE  (cond_raw),
    .BrOk     (br_ok)
  );

  assign live      = ValidE & ~FlushE;
  assign pcsrc_raw = armE ? (BranchE & cond_raw) : (JumpE | (BranchE & br_ok));

  assign FlagsE     = flags_q;
  assign CondExE    = live & cond_raw;
  assign PCSrcE     = live & pcsrc_raw;
  assign RegWriteGE = RegWriteE & CondExE;
  assign MemWriteGE = MemWriteE & CondExE;

  // A stalled instruction stays in E, so its flag write lands on the cycle
  // it finally leaves; the next ARM instruction then sees it directly.
  assign flag_we = armE & CondExE & ~StallE;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= RESET_FLAGS;
      BranchTakenM <= 1'b0;
    end else begin
      if (!StallE) begin
        BranchTakenM <= PCSrcE;
      end
      if (flag_we && FlagWriteE[1]) begin
        flags_q[N_IDX] <= ALUFlags[N_IDX];
        flags_q[Z_IDX] <= ALUFlags[Z_IDX];
      end
      if (flag_we && FlagWriteE[0]) begin
        flags_q[C_IDX] <= ALUFlags[C_IDX];
        flags_q[V_IDX] <= ALUFlags[V_IDX];
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_e.sv
module tb_cond_unit_e;

  localparam logic [3:0] RST_F = 4'b0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       armE, ValidE, StallE, FlushE;
  logic [3:0] CondE;
  logic [2:0] Funct3E;
  logic       BranchE, JumpE;
  logic [1:0] FlagWriteE;
  logic       RegWriteE, MemWriteE;
  logic [3:0] ALUFlags;
  logic [3:0] FlagsE;
  logic       CondExE, PCSrcE, RegWriteGE, MemWriteGE, BranchTakenM;

  int tests = 0;
  int fails = 0;

  logic [3:0] m_flags;
  logic       m_btm;
  bit         m_rv_taken;

  cond_unit_e #(.RESET_FLAGS(RST_F)) dut (
    .clk(clk), .reset(reset), .armE(armE), .ValidE(ValidE), .StallE(StallE),
    .FlushE(FlushE), .CondE(CondE), .Funct3E(Funct3E), .BranchE(BranchE),
    .JumpE(JumpE), .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUFlags(ALUFlags), .FlagsE(FlagsE),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteGE(RegWriteGE),
    .MemWriteGE(MemWriteGE), .BranchTakenM(BranchTakenM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ARM condition from the mnemonic table: even codes are the base test,
  // odd codes its complement; 111x always executes.
  function automatic bit arm_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic drv(input bit arm, input bit valid, input bit stall, input bit flush,
                     input logic [3:0] cond, input logic [2:0] f3, input bit br,
                     input bit jmp, input logic [1:0] fw, input bit rw, input bit mw,
                     input logic [3:0] alu, input bit rv_taken);
    armE = arm; ValidE = valid; StallE = stall; FlushE = flush; CondE = cond;
    Funct3E = f3; BranchE = br; JumpE = jmp; FlagWriteE = fw; RegWriteE = rw;
    MemWriteE = mw; ALUFlags = alu; m_rv_taken = rv_taken;
  endtask

  task automatic cycle(input string tag);
    bit live, ce, pcs;
    live = ValidE && !FlushE;
    ce   = armE ? arm_cond(CondE, m_flags) : 1'b1;
    pcs  = armE ? (BranchE && ce) : (JumpE || (BranchE && m_rv_taken));
    ce   = ce && live;
    pcs  = pcs && live;
    #2;
    chk({tag, ".condex"}, {3'b0, CondExE}, {3'b0, ce});
    chk({tag, ".pcsrc"},  {3'b0, PCSrcE},  {3'b0, pcs});
    chk({tag, ".regwr"},  {3'b0, RegWriteGE}, {3'b0, RegWriteE && ce});
    chk({tag, ".memwr"},  {3'b0, MemWriteGE}, {3'b0, MemWriteE && ce});
    chk({tag, ".flags_e"}, FlagsE, m_flags);
    @(posedge clk);
    if (reset) begin
      m_flags = RST_F;
      m_btm   = 1'b0;
    end else if (!StallE) begin
      m_btm = pcs;
      if (armE && ce) begin
        if (FlagWriteE[1]) m_flags[3:2] = ALUFlags[3:2];
        if (FlagWriteE[0]) m_flags[1:0] = ALUFlags[1:0];
      end
    end
    #1;
    chk({tag, ".flags_q"}, FlagsE, m_flags);
    chk({tag, ".btm"}, {3'b0, BranchTakenM}, {3'b0, m_btm});
  endtask

  initial begin
    logic [31:0] op1, op2, diff;
    bit sn, sz, sc, sv, tk;

    reset = 1'b1;
    drv(1, 1, 0, 0, 4'd14, 3'd0, 1, 0, 2'b11, 1, 1, 4'b1111, 0);
    @(posedge clk); @(posedge clk); #1;
    m_flags = RST_F; m_btm = 1'b0;
    chk("reset.flags", FlagsE, RST_F);
    chk("reset.btm", {3'b0, BranchTakenM}, 4'b0);
    reset = 1'b0;

    // CMP setting Z, then ADDEQ / ADDNE
    drv(1, 1, 0, 0, 4'd14, 3'd0, 0, 0, 2'b11, 0, 0, 4'b0100, 0); cycle("cmp");
    chk("cmp.result", FlagsE, 4'b0100);
    drv(1, 1, 0, 0, 4'd0,  3'd0, 0, 0, 2'b00, 1, 0, 4'b0000, 0); cycle("addeq");
    drv(1, 1, 0, 0, 4'd1,  3'd0, 0, 0, 2'b00, 1, 0, 4'b0000, 0); cycle("addne");

    // split write: only N,Z
    drv(1, 1, 0, 0, 4'd14, 3'd0, 0, 0, 2'b11, 0, 0, 4'b1111, 0); cycle("set1111");
    drv(1, 1, 0, 0, 4'd14, 3'd0, 0, 0, 2'b10, 0, 0, 4'b0000, 0); cycle("split");
    chk("split.result", FlagsE, 4'b0011);

    // failed condition suppresses flag write and branch
    drv(1, 1, 0, 0, 4'd14, 3'd0, 0, 0, 2'b11, 0, 0, 4'b0000, 0); cycle("clr");
    drv(1, 1, 0, 0, 4'd0,  3'd0, 1, 0, 2'b11, 1, 1, 4'b1000, 0); cycle("suppress");
    chk("suppress.result", FlagsE, 4'b0000);

    // RISC-V branches
    drv(0, 1, 0, 0, 4'd0, 3'b110, 1, 0, 2'b11, 0, 0, 4'b0010, 1); cycle("bltu");
    chk("bltu.btm_hi", {3'b0, BranchTakenM}, 4'b0001);
    drv(0, 0, 0, 0, 4'd0, 3'b000, 0, 0, 2'b00, 0, 0, 4'b0000, 0); cycle("bubble");
    chk("bltu.btm_lo", {3'b0, BranchTakenM}, 4'b0000);
    drv(0, 1, 0, 0, 4'd0, 3'b101, 1, 0, 2'b11, 0, 0, 4'b1001, 1); cycle("bge");
    drv(0, 1, 0, 0, 4'd0, 3'b010, 1, 0, 2'b00, 0, 0, 4'b0100, 0); cycle("f3_010");
    chk("rv.noflags", FlagsE, 4'b0000);

    // flushed taken ARM branch
    drv(1, 1, 0, 1, 4'd14, 3'd0, 1, 0, 2'b11, 1, 1, 4'b1111, 0); cycle("flush");
    chk("flush.btm", {3'b0, BranchTakenM}, 4'b0000);

    // stalled flag write lands on the first unstalled cycle
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 0, 4'd14, 3'd0, 0, 0, 2'b11, 0, 0, 4'b0110, 0); cycle("stall");
      chk("stall.hold", FlagsE, 4'b0000);
    end
    drv(1, 1, 0, 0, 4'd14, 3'd0, 0, 0, 2'b11, 0, 0, 4'b0110, 0); cycle("unstall");
    chk("unstall.result", FlagsE, 4'b0110);

    // reset overrides an in-flight write and a taken branch
    drv(1, 1, 0, 0, 4'd14, 3'd0, 1, 0, 2'b11, 0, 0, 4'b1010, 0); cycle("pre_rst");
    chk("pre_rst.flags", FlagsE, 4'b1010);
    reset = 1'b1;
    drv(1, 1, 0, 0, 4'd14, 3'd0, 1, 0, 2'b11, 0, 0, 4'b0101, 0); cycle("mid_rst");
    chk("mid_rst.flags", FlagsE, RST_F);
    chk("mid_rst.btm", {3'b0, BranchTakenM}, 4'b0000);
    reset = 1'b0;

    // randomized mix; RISC-V flags come from a real subtract of random operands
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      armE       = 1'($urandom_range(0, 1));
      ValidE     = ($urandom_range(0, 7) != 0);
      StallE     = ($urandom_range(0, 3) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      CondE      = 4'($urandom);
      Funct3E    = 3'($urandom);
      BranchE    = 1'($urandom_range(0, 1));
      JumpE      = ($urandom_range(0, 5) == 0);
      FlagWriteE = 2'($urandom);
      RegWriteE  = 1'($urandom_range(0, 1));
      MemWriteE  = 1'($urandom_range(0, 1));
      if (armE) begin
        ALUFlags   = 4'($urandom);
        m_rv_taken = 1'b0;
      end else begin
        op1 = $urandom;
        case ($urandom_range(0, 3))
          0: op2 = op1;
          1: begin op1 = 32'($urandom_range(0, 3)); op2 = 32'($urandom_range(0, 3)); end
          default: op2 = $urandom;
        endcase
        diff = op1 - op2;
        sn = diff[31];
        sz = (diff == 32'd0);
        sc = (op1 < op2);
        sv = (op1[31] != op2[31]) && (diff[31] != op1[31]);
        ALUFlags = {sn, sz, sc, sv};
        case (Funct3E)
          3'b000: tk = (op1 == op2);
          3'b001: tk = (op1 != op2);
          3'b100: tk = ($signed(op1) < $signed(op2));
          3'b101: tk = ($signed(op1) >= $signed(op2));
          3'b110: tk = (op1 < op2);
          3'b111: tk = (op1 >= op2);
          default: tk = 1'b0;
        endcase
        m_rv_taken = tk;
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
